frame_sum_accumulator: RTL and testbench
========================================

Name: frame_sum_accumulator

Overview:
- Downstream consumer of the 32-bit ripple adder stage; accumulates a stream of operand words into a running sum, one word per accepted beat.
- Emits one result per frame with sticky carry, signed-overflow and beat-count status.
- Valid/ready handshakes on both sides let it sit between an operand source and a result sink in the arithmetic datapath.

Parameters:
- WIDTH, 32, data/sum width in bits
- CNT_W, 16, width of beat counter
- SATURATE, 0, 1 = clamp sum to all-ones on unsigned carry; 0 = wrap modulo 2^WIDTH

Ports:
- Clk  input  1  clock, rising edge
- Rst_n  input  1  asynchronous active-low reset
- In_valid  input  1  input beat valid
- In_ready  output  1  block can accept a beat
- In_data  input  WIDTH  operand word
- In_last  input  1  beat is final word of frame
- Out_valid  output  1  result valid
- Out_ready  input  1  sink accepts result
- Out_sum  output  WIDTH  frame sum
- Out_carry  output  1  sticky: any unsigned carry-out during frame
- Out_overflow  output  1  sticky: any two's-complement overflow during frame
- Out_count  output  CNT_W  beats in frame, saturating at 2^CNT_W-1

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All outputs 0; In_ready=0 while Rst_n low.
  - State IDLE, accumulator 0, sticky flags 0, count 0.
- States:
  - IDLE: In_ready=1. An accepted beat loads acc=0+In_data, count=1, flags from that add (no carry/overflow possible).
    - In_last=1 -> HOLD.
    - Else -> ACCUM.
  - ACCUM: In_ready=1. Accepted beat: acc=acc+In_data via adder core (Cin=0); carry flag |= Cout; ovf flag |= (acc[MSB]==In_data[MSB] && sum[MSB]!=acc[MSB]); count += 1 unless saturated.
    - In_last=1 -> HOLD.
  - HOLD: In_ready=0. Out_valid=1; Out_sum/flags/count stable and registered.
    - Out_valid && Out_ready -> IDLE next cycle; accumulator and flags cleared.
- Accept = In_valid && In_ready. Out_* update only on the cycle In_last is accepted. Latency: Out_valid asserts the cycle after the last beat is accepted.
- SATURATE=1:
  - Once the carry flag sets, acc holds all-ones for the rest of the frame.
  - Overflow is still tracked on the raw adder result.
- In_valid low in ACCUM: hold state; no timeout.
- In_data/In_last are ignored when not accepted.
- Out_ready asserted without Out_valid: no effect.
- Out_valid never deasserts without a handshake, and outputs never change while Out_valid=1.
- Throughput: one beat per cycle within a frame. One bubble cycle on the input after each frame (HOLD minimum 1 cycle).
- Reset mid-frame or in HOLD: partial frame discarded, no result emitted.

Decomposition:
- Package frame_sum_pkg: state enum {IDLE, ACCUM, HOLD}; constants DEF_WIDTH=32, DEF_CNT_W=16.
- One sub-module: add_core_w, a combinational WIDTH-bit adder (A, B, Cin -> Sum, Cout). Instantiated once.
- FSM, counter and sticky flags stay in the top module.

Test Plan:
- Frame 1,2,3 (last on 3), Out_ready=1 -> one cycle after last: Out_sum=6, carry=0, ovf=0, count=3; Out_valid drops the next cycle.
- Frame 32'hFFFFFFFF, 32'h2 -> Out_sum=32'h1, carry=1, ovf=0, count=2. Same frame with SATURATE=1 -> Out_sum=32'hFFFFFFFF, carry=1.
- Frame 32'h7FFFFFFF, 32'h1 -> Out_sum=32'h80000000, ovf=1, carry=0.
- Single-beat frame 32'hA5, Out_ready held low 5 cycles -> Out_valid=1 and outputs stable all 5 cycles, In_ready=0. Raise Out_ready -> IDLE, In_ready=1 the next cycle.
- Back-to-back frames {5,last} {7,last} with In_valid held high -> results 5 then 7, each count=1, one-cycle In_ready bubble between frames.
- Rst_n pulsed low after 2 beats of a 4-beat frame -> all outputs 0 immediately. A new frame {9,last} yields Out_sum=9, count=1.

Source files
------------

// File: rtl/frame_sum_accumulator_pkg.sv
// ============================================================================
// Module  : frame_sum_pkg
// Purpose : Shared state encoding and default widths for frame_sum_accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package frame_sum_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/frame_sum_accumulator_if.sv
// ============================================================================
// Module  : frame_sum_accumulator_if
// Purpose : Operand-in / result-out handshake bundle for the frame accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface frame_sum_accumulator_if
  import frame_sum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_overflow;
  logic [CNT_W-1:0] out_count;

  // Source of operands and sink of results
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_overflow, out_count
  );

  // The accumulator itself
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_overflow, out_count
  );

endinterface

`default_nettype wire

// File: rtl/frame_sum_accumulator_add_core.sv
// ============================================================================
// Module  : add_core_w
// Purpose : Combinational WIDTH-bit adder with carry-in and carry-out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module add_core_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

`default_nettype wire

// File: rtl/frame_sum_accumulator.sv
// ============================================================================
// Module  : frame_sum_accumulator
// Purpose : Sums operand beats per frame; emits sum, sticky carry/overflow, count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_sum_accumulator
  import frame_sum_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  frame_sum_accumulator_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_carry_q, res_carry_d;
  logic             res_ovf_q, res_ovf_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

  logic             accept;
  logic             in_frame;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             beat_ovf;
  logic             frame_carry;
  logic             frame_ovf;
  logic [WIDTH-1:0] frame_acc;
  logic [CNT_W-1:0] frame_cnt;

  assign accept   = bus.in_valid && in_ready_q;
  assign in_frame = (state_q == ACCUM);

  // First beat of a frame adds onto zero, so its flags come out clear
  assign add_a = in_frame ? acc_q : '0;

  add_core_w #(
    .WIDTH (WIDTH)
  ) u_add (
    .a_i    (add_a),
    .b_i    (bus.in_data),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign beat_ovf    = (add_a[MSB] == bus.in_data[MSB]) && (add_sum[MSB] != add_a[MSB]);
  assign frame_carry = (in_frame && carry_q) || add_cout;
  assign frame_ovf   = (in_frame && ovf_q) || beat_ovf;
  assign frame_acc   = ((SATURATE != 0) && frame_carry) ? {WIDTH{1'b1}} : add_sum;
  assign frame_cnt   = !in_frame ? CNT_W'(1)
                     : (&cnt_q)  ? cnt_q
                     :             cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    res_sum_d   = res_sum_q;
    res_carry_d = res_carry_q;
    res_ovf_d   = res_ovf_q;
    res_cnt_d   = res_cnt_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = frame_acc;
          carry_d = frame_carry;
          ovf_d   = frame_ovf;
          cnt_d   = frame_cnt;
          if (bus.in_last) begin
            state_d     = HOLD;
            res_sum_d   = frame_acc;
            res_carry_d = frame_carry;
            res_ovf_d   = frame_ovf;
            res_cnt_d   = frame_cnt;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d != HOLD);
  end

  // in_ready is registered so it stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      res_sum_q   <= res_sum_d;
      res_carry_q <= res_carry_d;
      res_ovf_q   <= res_ovf_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = (state_q == HOLD);
  assign bus.out_sum      = res_sum_q;
  assign bus.out_carry    = res_carry_q;
  assign bus.out_overflow = res_ovf_q;
  assign bus.out_count    = res_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_sum_accumulator.sv
// ============================================================================
// Module  : tb_frame_sum_accumulator
// Purpose : Directed self-checking bench for frame_sum_accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_sum_accumulator;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  frame_sum_accumulator_if #(.WIDTH(32), .CNT_W(16)) bus  ();
  frame_sum_accumulator_if #(.WIDTH(32), .CNT_W(2))  sbus ();

  frame_sum_accumulator #(.WIDTH(32), .CNT_W(16), .SATURATE(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Saturating variant with a narrow counter so count saturation is reachable
  frame_sum_accumulator #(.WIDTH(32), .CNT_W(2), .SATURATE(1)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_s(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    sbus.in_valid = 1'b1;
    sbus.in_data  = d;
    sbus.in_last  = l;
    while (sbus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_s_timeout: in_ready=%b after %0d cycles, required 1", sbus.in_ready, n);
    end
    @(negedge clk);
    sbus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count}
        !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b ready=%b sum=%h c=%b v=%b cnt=%0d, required all 0",
               bus.out_valid, bus.in_ready, bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_sum_basic();
    bus.out_ready = 1'b1;
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL basic_handshake: valid=%b ready=%b, required 1 0", bus.out_valid, bus.in_ready);
    end
    checks++;
    if ({bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count} !== {32'd6, 1'b0, 1'b0, 16'd3}) begin
      errors++;
      $display("FAIL basic_result: sum=%0d c=%b v=%b cnt=%0d, required 6 0 0 3",
               bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_release: valid=%b ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_carry();
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0002, 1'b1);
    checks++;
    if ({bus.out_valid, bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count}
        !== {1'b1, 32'h1, 1'b1, 1'b0, 16'd2}) begin
      errors++;
      $display("FAIL carry_result: valid=%b sum=%h c=%b v=%b cnt=%0d, required 1 00000001 1 0 2",
               bus.out_valid, bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    send(32'h7FFF_FFFF, 1'b0);
    send(32'h0000_0001, 1'b1);
    checks++;
    if ({bus.out_valid, bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count}
        !== {1'b1, 32'h8000_0000, 1'b0, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL ovf_result: valid=%b sum=%h c=%b v=%b cnt=%0d, required 1 80000000 0 1 2",
               bus.out_valid, bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count);
    end
    @(negedge clk);
    // Carry and overflow must not leak into the following frame
    send(32'd10, 1'b0);
    send(32'd20, 1'b1);
    checks++;
    if ({bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count} !== {32'd30, 1'b0, 1'b0, 16'd2}) begin
      errors++;
      $display("FAIL flags_cleared: sum=%0d c=%b v=%b cnt=%0d, required 30 0 0 2",
               bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    send(32'hA5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      // Junk on the input must be ignored while holding
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h1234_0000 + i;
      bus.in_last  = 1'b1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count}
          !== {1'b1, 1'b0, 32'hA5, 1'b0, 1'b0, 16'd1}) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b ready=%b sum=%h cnt=%0d, required 1 0 000000a5 1",
                 i, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_count);
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release: valid=%b ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'd5;
    bus.in_last   = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_sum, bus.out_count} !== {1'b1, 1'b0, 32'd5, 16'd1}) begin
      errors++;
      $display("FAIL b2b_first: valid=%b ready=%b sum=%0d cnt=%0d, required 1 0 5 1",
               bus.out_valid, bus.in_ready, bus.out_sum, bus.out_count);
    end
    bus.in_data = 32'd7;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_bubble: valid=%b ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_sum, bus.out_count} !== {1'b1, 32'd7, 16'd1}) begin
      errors++;
      $display("FAIL b2b_second: valid=%b sum=%0d cnt=%0d, required 1 7 1",
               bus.out_valid, bus.out_sum, bus.out_count);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    sbus.out_ready = 1'b1;
    send_s(32'hFFFF_FFFF, 1'b0);
    send_s(32'h0000_0002, 1'b1);
    checks++;
    if ({sbus.out_valid, sbus.out_sum, sbus.out_carry, sbus.out_overflow, sbus.out_count}
        !== {1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL sat_clamp: valid=%b sum=%h c=%b v=%b cnt=%0d, required 1 ffffffff 1 0 2",
               sbus.out_valid, sbus.out_sum, sbus.out_carry, sbus.out_overflow, sbus.out_count);
    end
    @(negedge clk);
    send_s(32'hFFFF_FFFF, 1'b0);
    send_s(32'h0000_0002, 1'b0);
    send_s(32'h0000_0005, 1'b1);
    checks++;
    if ({sbus.out_sum, sbus.out_carry, sbus.out_overflow, sbus.out_count}
        !== {32'hFFFF_FFFF, 1'b1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL sat_sticky: sum=%h c=%b v=%b cnt=%0d, required ffffffff 1 0 3",
               sbus.out_sum, sbus.out_carry, sbus.out_overflow, sbus.out_count);
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) send_s(32'd1, (i == 4));
    checks++;
    if ({sbus.out_sum, sbus.out_carry, sbus.out_count} !== {32'd5, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL count_saturate: sum=%0d c=%b cnt=%0d, required 5 0 3",
               sbus.out_sum, sbus.out_carry, sbus.out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    bus.out_ready = 1'b1;
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count}
        !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL midframe_reset: valid=%b ready=%b sum=%h cnt=%0d, required all 0",
               bus.out_valid, bus.in_ready, bus.out_sum, bus.out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'd9, 1'b1);
    checks++;
    if ({bus.out_valid, bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count}
        !== {1'b1, 32'd9, 1'b0, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL after_reset_frame: valid=%b sum=%0d c=%b v=%b cnt=%0d, required 1 9 0 0 1",
               bus.out_valid, bus.out_sum, bus.out_carry, bus.out_overflow, bus.out_count);
    end
    @(negedge clk);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    sbus.in_valid  = 1'b0;
    sbus.in_data   = '0;
    sbus.in_last   = 1'b0;
    sbus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    test_reset();
    test_sum_basic();
    test_carry();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_saturate();
    test_reset_mid_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
